alu_issue_stage: RTL and testbench

// - Execute-issue stage directly upstream of the ALU.
// - Decodes RV32I OP/OP-IMM/LUI/AUIPC instructions and selects operands into one pipeline register.
// - Drives the ALU op/op2/x/y inputs and receives the ALU result back for EX->EX forwarding.
// - valid/ready handshake on both sides; flush support; illegal-encoding flag.

---
 rtl/alu_issue_stage.sv | 188 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Execute-issue stage ahead of the ALU: decodes RV32I OP/OP-IMM/LUI/AUIPC into one held slot.
// Optional macro EX_FWD_EN: EX->EX and WB forwarding instead of the read-after-write stall.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RIDX = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [31:0]     i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_wb_en,
  input  logic [RIDX-1:0] i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_flush,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [2:0]      o_op,
  output logic            o_op2,
  output logic [XLEN-1:0] o_x,
  output logic [XLEN-1:0] o_y,
  output logic [RIDX-1:0] o_rd,
  output logic            o_illegal
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SR     = 3'b101;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RIDX-1:0] rs1_idx;
  logic [RIDX-1:0] rs2_idx;
  logic [RIDX-1:0] rd_idx;
  logic            is_shift;

  assign opcode   = i_instr[6:0];
  assign funct3   = i_instr[14:12];
  assign funct7   = i_instr[31:25];
  assign rs1_idx  = RIDX'(i_instr[19:15]);
  assign rs2_idx  = RIDX'(i_instr[24:20]);
  assign rd_idx   = RIDX'(i_instr[11:7]);
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            stall;

  logic [2:0]      dec_op;
  logic            dec_op2;
  logic [XLEN-1:0] dec_x;
  logic [XLEN-1:0] dec_y;
  logic [RIDX-1:0] dec_rd;
  logic            dec_illegal;
  logic            use_rs1;
  logic            use_rs2;

`ifdef EX_FWD_EN
  logic ex_fwd_ok;
  assign ex_fwd_ok = o_valid & i_ready;

  // Operand priority: EX result of the draining instruction, then writeback, then register file.
  always_comb begin
    rs1_val = i_rs1_data;
    if (rs1_idx == '0)
      rs1_val = '0;
    else if (ex_fwd_ok && (o_rd == rs1_idx))
      rs1_val = i_alu_result;
    else if (i_wb_en && (i_wb_rd == rs1_idx))
      rs1_val = i_wb_data;
  end

  always_comb begin
    rs2_val = i_rs2_data;
    if (rs2_idx == '0)
      rs2_val = '0;
    else if (ex_fwd_ok && (o_rd == rs2_idx))
      rs2_val = i_alu_result;
    else if (i_wb_en && (i_wb_rd == rs2_idx))
      rs2_val = i_wb_data;
  end

  assign stall = 1'b0;
`else
  // Write-first register file covers writeback; only the held result needs a stall.
  assign rs1_val = (rs1_idx == '0) ? '0 : i_rs1_data;
  assign rs2_val = (rs2_idx == '0) ? '0 : i_rs2_data;
  assign stall   = o_valid && (o_rd != '0) &&
                   ((use_rs1 && (o_rd == rs1_idx)) || (use_rs2 && (o_rd == rs2_idx)));

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{i_wb_en, i_wb_rd, i_wb_data, i_alu_result};
`endif

  // Decode; anything not explicitly legal leaves the illegal defaults in place.
  always_comb begin
    dec_op      = F3_ADD;
    dec_op2     = 1'b0;
    dec_x       = '0;
    dec_y       = '0;
    dec_rd      = '0;
    dec_illegal = 1'b1;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if ((funct7 == F7_BASE) ||
            ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)))) begin
          dec_op      = funct3;
          dec_op2     = ((funct3 == F3_ADD) || (funct3 == F3_SR)) ? i_instr[30] : 1'b0;
          dec_x       = rs1_val;
          dec_y       = is_shift ? XLEN'(rs2_val[4:0]) : rs2_val;
          dec_rd      = rd_idx;
          dec_illegal = 1'b0;
          use_rs1     = 1'b1;
          use_rs2     = 1'b1;
        end
      end
      OPC_OPIMM: begin
        if (!is_shift ||
            ((funct3 == F3_SLL) && (funct7 == F7_BASE)) ||
            ((funct3 == F3_SR) && ((funct7 == F7_BASE) || (funct7 == F7_ALT)))) begin
          dec_op      = funct3;
          dec_op2     = (funct3 == F3_SR) ? i_instr[30] : 1'b0;
          dec_x       = rs1_val;
          dec_y       = is_shift ? XLEN'(i_instr[24:20])
                                 : {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
          dec_rd      = rd_idx;
          dec_illegal = 1'b0;
          use_rs1     = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_y       = XLEN'({i_instr[31:12], 12'b0});
        dec_rd      = rd_idx;
        dec_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec_x       = XLEN'(i_pc);
        dec_y       = XLEN'({i_instr[31:12], 12'b0});
        dec_rd      = rd_idx;
        dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  logic capture;
  assign o_ready = (~o_valid | i_ready) & ~stall;
  assign capture = i_valid & o_ready & ~i_flush;

  // Flush kills the slot but leaves the payload registers untouched.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_op      <= '0;
      o_op2     <= 1'b0;
      o_x       <= '0;
      o_y       <= '0;
      o_rd      <= '0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (capture) begin
      o_valid   <= 1'b1;
      o_op      <= dec_op;
      o_op2     <= dec_op2;
      o_x       <= dec_x;
      o_y       <= dec_y;
      o_rd      <= dec_rd;
      o_illegal <= dec_illegal;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; expectations follow the build's EX_FWD_EN setting.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_out, wb_en, flush, ready_in;
  logic [31:0] instr, pc, rs1_data, rs2_data, wb_data, alu_result;
  logic [4:0]  wb_rd;
  logic        valid_out, op2, illegal;
  logic [2:0]  op;
  logic [31:0] x, y;
  logic [4:0]  rd;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready_out),
    .i_instr(instr), .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data),
    .i_wb_en(wb_en), .i_wb_rd(wb_rd), .i_wb_data(wb_data), .i_alu_result(alu_result),
    .i_flush(flush), .i_ready(ready_in), .o_valid(valid_out), .o_op(op), .o_op2(op2),
    .o_x(x), .o_y(y), .o_rd(rd), .o_illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_held(input string tag, input logic [2:0] e_op, input logic e_op2,
                            input logic [31:0] e_x, input logic [31:0] e_y,
                            input logic [4:0] e_rd, input logic e_ill);
    check({tag, ".valid"}, 32'(valid_out), 32'd1);
    check({tag, ".op"}, 32'(op), 32'(e_op));
    check({tag, ".op2"}, 32'(op2), 32'(e_op2));
    check({tag, ".x"}, x, e_x);
    check({tag, ".y"}, y, e_y);
    check({tag, ".rd"}, 32'(rd), 32'(e_rd));
    check({tag, ".ill"}, 32'(illegal), 32'(e_ill));
  endtask

  // Present one instruction for one edge; the stage must be ready for it.
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    instr = ins; rs1_data = a; rs2_data = b; valid_in = 1'b1;
    #1;
    check({tag, ".rdy"}, 32'(ready_out), 32'd1);
    tick();
    valid_in = 1'b0;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rdi);
    return {f7, rs2, rs1, f3, rdi, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rdi);
    return {imm, rs1, f3, rdi, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rdi,
                                        input logic [6:0] opc);
    return {imm, rdi, opc};
  endfunction

  initial begin
    rst = 1'b1; valid_in = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; alu_result = '0; flush = 1'b0; ready_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset.valid", 32'(valid_out), 32'd0);
    check("reset.x", x, 32'd0);
    check("reset.rd", 32'(rd), 32'd0);

    // srai x5,x6,3 with i_ready low, then hold for two cycles
    issue("srai", 32'h40335293, 32'h80000000, 32'hFFFFFFFF);
    check_held("srai", 3'b101, 1'b1, 32'h80000000, 32'd3, 5'd5, 1'b0);
    instr = enc_u(20'h12345, 5'd1, 7'b0110111); valid_in = 1'b1;
    #1;
    check("hold.rdy", 32'(ready_out), 32'd0);
    tick(); tick();
    valid_in = 1'b0;
    check_held("hold", 3'b101, 1'b1, 32'h80000000, 32'd3, 5'd5, 1'b0);

    // asynchronous reset while holding
    rst = 1'b1;
    #1;
    check("rstmid.valid", 32'(valid_out), 32'd0);
    check("rstmid.x", x, 32'd0);
    check("rstmid.y", y, 32'd0);
    check("rstmid.rd", 32'(rd), 32'd0);
    check("rstmid.op", 32'(op), 32'd0);
    check("rstmid.op2", 32'(op2), 32'd0);
    rst = 1'b0;
    ready_in = 1'b1;
    tick();

    issue("addi800", enc_i(12'h800, 5'd1, 3'b000, 5'd7), 32'h10, 32'h0);
    check_held("addi800", 3'b000, 1'b0, 32'h10, 32'hFFFFF800, 5'd7, 1'b0);
    issue("addi400", enc_i(12'h400, 5'd1, 3'b000, 5'd8), 32'h20, 32'h0);
    check_held("addi400", 3'b000, 1'b0, 32'h20, 32'h400, 5'd8, 1'b0);
    issue("lui", enc_u(20'h12345, 5'd1, 7'b0110111), 32'hAAAA, 32'hBBBB);
    check_held("lui", 3'b000, 1'b0, 32'h0, 32'h12345000, 5'd1, 1'b0);
    pc = 32'h100;
    issue("auipc", enc_u(20'h00001, 5'd2, 7'b0010111), 32'hAAAA, 32'hBBBB);
    check_held("auipc", 3'b000, 1'b0, 32'h100, 32'h1000, 5'd2, 1'b0);
    issue("opc7f", 32'h000001FF, 32'h1234, 32'h5678);
    check_held("opc7f", 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
    issue("mulf7", enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd6), 32'h3, 32'h4);
    check_held("mulf7", 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
    issue("slli_alt", enc_i({7'b0100000, 5'd2}, 5'd1, 3'b001, 5'd1), 32'h3, 32'h4);
    check_held("slli_alt", 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);

    // add x3,x1,x2 then sub x4,x3,x3 back to back
    issue("add", enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h11, 32'h44);
    check_held("add", 3'b000, 1'b0, 32'h11, 32'h44, 5'd3, 1'b0);
    instr = enc_r(7'b0100000, 5'd3, 5'd3, 3'b000, 5'd4);
    rs1_data = 32'hDEAD; rs2_data = 32'hDEAD; alu_result = 32'h55; valid_in = 1'b1;
    #1;
`ifdef EX_FWD_EN
    check("sub.rdy", 32'(ready_out), 32'd1);
    tick();
`else
    check("sub.stall", 32'(ready_out), 32'd0);
    tick();
    rs1_data = 32'h55; rs2_data = 32'h55;
    check("sub.drain", 32'(valid_out), 32'd0);
    #1;
    check("sub.rdy", 32'(ready_out), 32'd1);
    tick();
`endif
    valid_in = 1'b0;
    check_held("sub", 3'b000, 1'b1, 32'h55, 32'h55, 5'd4, 1'b0);

    issue("sra", enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd9), 32'hF0000000, 32'hFFFFFF23);
    check_held("sra", 3'b101, 1'b1, 32'hF0000000, 32'h3, 5'd9, 1'b0);

    // flush with held and incoming both valid
    ready_in = 1'b0; flush = 1'b1; valid_in = 1'b1;
    instr = enc_i(12'h001, 5'd1, 3'b000, 5'd10); rs1_data = 32'h99;
    tick();
    flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    check("flush.valid", 32'(valid_out), 32'd0);
    check("flush.keepx", x, 32'hF0000000);

    // writeback bypass and x0 read
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h77;
    issue("wbfwd", enc_r(7'b0000000, 5'd0, 5'd1, 3'b000, 5'd5), 32'h11, 32'hCAFE);
    wb_en = 1'b0;
`ifdef EX_FWD_EN
    check_held("wbfwd", 3'b000, 1'b0, 32'h77, 32'h0, 5'd5, 1'b0);
`else
    check_held("wbfwd", 3'b000, 1'b0, 32'h11, 32'h0, 5'd5, 1'b0);
`endif
    tick();
    check("drain.valid", 32'(valid_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
